// File: rtl/board_pkg.sv
// Shared types and constants for the board pixel generator.
package board_pkg;

  localparam int unsigned BOARD_N = 8;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    PLAYER_A = 2'd1,
    PLAYER_B = 2'd2,
    MARKER   = 2'd3
  } piece_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_BLANK  = '{r: 4'd0,  g: 4'd0,  b: 4'd0};
  localparam rgb_t COL_BG     = '{r: 4'd0,  g: 4'd0,  b: 4'd4};
  localparam rgb_t COL_CURSOR = '{r: 4'd15, g: 4'd15, b: 4'd0};
  localparam rgb_t COL_A      = '{r: 4'd15, g: 4'd0,  b: 4'd0};
  localparam rgb_t COL_B      = '{r: 4'd15, g: 4'd15, b: 4'd15};
  localparam rgb_t COL_MARKER = '{r: 4'd0,  g: 4'd15, b: 4'd0};
  localparam rgb_t COL_LIGHT  = '{r: 4'd12, g: 4'd8,  b: 4'd4};
  localparam rgb_t COL_DARK   = '{r: 4'd6,  g: 4'd3,  b: 4'd1};

endpackage

// File: rtl/board_store.sv
// 8x8 board-state store: one synchronous write port, one combinational read port.
module board_store
  import board_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [1:0] wr_piece,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_piece
);

  piece_t cells [BOARD_N*BOARD_N];

  // Clear all cells on reset, otherwise write one cell per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BOARD_N*BOARD_N; i++) begin
        cells[i] <= EMPTY;
      end
    end else if (wr_en) begin
      cells[{wr_row, wr_col}] <= piece_t'(wr_piece);
    end
  end

  assign rd_piece = cells[{rd_row, rd_col}];

endmodule

// File: rtl/board_pixel_gen.sv
// Board renderer: two-stage pixel pipeline driven by VGA timing coordinates.
module board_pixel_gen
  import board_pkg::*;
#(
  parameter int unsigned BOARD_X0     = 320,
  parameter int unsigned BOARD_Y0     = 80,
  parameter int unsigned CELL_PX      = 80,
  parameter int unsigned DISC_R       = 30,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] curr_x,
  input  logic [9:0]  curr_y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [2:0]  wr_col,
  input  logic [1:0]  wr_piece,
  input  logic        cursor_en,
  input  logic [2:0]  cursor_row,
  input  logic [2:0]  cursor_col,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick
);

  localparam int unsigned CW  = $clog2(CELL_PX);
  localparam int unsigned BCW = $clog2(BLINK_FRAMES);

  localparam logic [10:0]       X0       = 11'(BOARD_X0);
  localparam logic [10:0]       X1       = 11'(BOARD_X0 + BOARD_N*CELL_PX);
  localparam logic [9:0]        Y0       = 10'(BOARD_Y0);
  localparam logic [9:0]        Y1       = 10'(BOARD_Y0 + BOARD_N*CELL_PX);
  localparam logic [CW-1:0]     D_LAST   = CW'(CELL_PX - 1);
  localparam logic [CW-1:0]     EDGE_LO  = CW'(4);
  localparam logic [CW-1:0]     EDGE_HI  = CW'(CELL_PX - 4);
  localparam logic signed [7:0] CTR      = 8'(CELL_PX / 2);
  localparam logic [15:0]       R_SQ     = 16'(DISC_R * DISC_R);
  localparam logic [BCW-1:0]    BLK_LAST = BCW'(BLINK_FRAMES - 1);

  // Stage-1 state: cell coordinates and offsets tracked incrementally.
  logic [2:0]    row, col, row_n, col_n;
  logic [CW-1:0] dx, dy, dx_n, dy_n;
  logic          s1_blank, s1_in_board;
  piece_t        s1_cell;
  logic [1:0]    rd_piece;
  logic          blank_n, in_board_n;

  logic [9:0]     prev_y;
  logic [BCW-1:0] blink_cnt;
  logic           blink_on;

  rgb_t       pix, colour;
  logic [1:0] hs_d, vs_d;

  board_store u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_piece (wr_piece),
    .rd_row   (row_n),
    .rd_col   (col_n),
    .rd_piece (rd_piece)
  );

  // Next column/x-offset: restart at the board's left edge, count across it.
  always_comb begin
    col_n = col;
    dx_n  = dx;
    if (curr_x == X0) begin
      col_n = '0;
      dx_n  = '0;
    end else if (curr_x > X0 && curr_x < X1) begin
      if (dx == D_LAST) begin
        dx_n  = '0;
        col_n = col + 3'd1;
      end else begin
        dx_n = dx + CW'(1);
      end
    end
  end

  // Next row/y-offset: advanced once per line at x==0, restart at the top edge.
  always_comb begin
    row_n = row;
    dy_n  = dy;
    if (curr_x == '0) begin
      if (curr_y == Y0) begin
        row_n = '0;
        dy_n  = '0;
      end else if (curr_y > Y0 && curr_y < Y1) begin
        if (dy == D_LAST) begin
          dy_n  = '0;
          row_n = row + 3'd1;
        end else begin
          dy_n = dy + CW'(1);
        end
      end
    end
  end

  // Region flags for the incoming pixel.
  always_comb begin
    blank_n    = (curr_x == '1) || (curr_y == '1);
    in_board_n = (curr_x >= X0) && (curr_x < X1) && (curr_y >= Y0) && (curr_y < Y1);
  end

  // Stage 1 register: cell position, region flags and cell contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      dx          <= '0;
      dy          <= '0;
      s1_blank    <= 1'b1;
      s1_in_board <= 1'b0;
      s1_cell     <= EMPTY;
    end else begin
      row         <= row_n;
      col         <= col_n;
      dx          <= dx_n;
      dy          <= dy_n;
      s1_blank    <= blank_n;
      s1_in_board <= in_board_n;
      s1_cell     <= piece_t'(rd_piece);
    end
  end

  // Previous line number, used to spot the start of vertical blanking.
  always_ff @(posedge clk) begin
    if (rst) prev_y <= '1;
    else     prev_y <= curr_y;
  end

  assign frame_tick = !rst && (prev_y != '1) && (curr_y == '1);

  // Cursor blink: toggle every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BCW'(1);
      end
    end
  end

  // Stage 2 colour selection, highest priority first.
  always_comb begin
    logic signed [7:0]  ox, oy;
    logic signed [15:0] oxw, oyw;
    logic [15:0]        sqx, sqy;
    logic               border, in_disc;
    ox      = $signed(8'(dx)) - CTR;
    oy      = $signed(8'(dy)) - CTR;
    oxw     = {{8{ox[7]}}, ox};
    oyw     = {{8{oy[7]}}, oy};
    sqx     = oxw * oxw;
    sqy     = oyw * oyw;
    in_disc = (sqx + sqy) <= R_SQ;
    border  = (dx < EDGE_LO) || (dx >= EDGE_HI) || (dy < EDGE_LO) || (dy >= EDGE_HI);
    colour  = COL_BLANK;
    if (s1_blank) begin
      colour = COL_BLANK;
    end else if (!s1_in_board) begin
      colour = COL_BG;
    end else if (cursor_en && blink_on && row == cursor_row && col == cursor_col && border) begin
      colour = COL_CURSOR;
    end else if (s1_cell != EMPTY && in_disc) begin
      case (s1_cell)
        PLAYER_A: colour = COL_A;
        PLAYER_B: colour = COL_B;
        default:  colour = COL_MARKER;
      endcase
    end else if ((row[0] ^ col[0]) == 1'b0) begin
      colour = COL_LIGHT;
    end else begin
      colour = COL_DARK;
    end
  end

  // Stage 2 register: colour output and matching sync delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix  <= COL_BLANK;
      hs_d <= '0;
      vs_d <= '0;
    end else begin
      pix  <= colour;
      hs_d <= {hs_d[0], hsync_in};
      vs_d <= {vs_d[0], vsync_in};
    end
  end

  assign pix_r     = pix.r;
  assign pix_g     = pix.g;
  assign pix_b     = pix.b;
  assign hsync_out = hs_d[1];
  assign vsync_out = vs_d[1];

endmodule
